ctrl_fetch_fsm: RTL and testbench

Multicycle fetch/control unit sitting directly upstream of DATAPATH. It owns the PC, fetches instruction words from instruction memory with a valid handshake, latches them into an instruction register, and sequences per-instruction states. In each state it drives DATAPATH's control inputs (br, regdst, enable, alusrc, sign, sel) plus data-memory strobes. Supported MIPS subset: R-type add/sub/and/or/slt, addi, lw, sw, beq, j, halt.

---
 rtl/ctrl_fetch_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_ctrl_fetch_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fetch_fsm.sv
// Fetch/control sequencer for the multicycle MIPS-subset datapath; owns PC and IR.
// Latency incl. fetch-accept cycle: R/addi 4, lw 5, sw 4, beq/j 3, illegal 2.
// Backpressure: parks in FETCH with fetch_req high until instr_valid; data memory is zero-wait.
module ctrl_fetch_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        zero,
    output logic [31:0] pc,
    output logic        fetch_req,
    output logic        br,
    output logic        regdst,
    output logic        enable,
    output logic        alusrc,
    output logic [31:0] sign,
    output logic [3:0]  sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        memtoreg,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Decoded view of the latched instruction; legal means "proceeds to EXEC".
    typedef struct packed {
        logic       legal;
        logic       halt;
        logic       rtype;
        logic       imm_alu;
        logic       load;
        logic       store;
        logic       branch;
        logic       jump;
        logic [3:0] alu_sel;
    } dec_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic [31:0] sign_ext;
    logic        alu_phase;
    dec_t        dec;

    assign sign_ext = {{16{ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        dec = '0;
        unique case (ir_q[31:26])
            OP_RTYPE: begin
                unique case (ir_q[5:0])
                    FN_ADD:  begin dec.legal = 1'b1; dec.rtype = 1'b1; dec.alu_sel = ALU_ADD; end
                    FN_SUB:  begin dec.legal = 1'b1; dec.rtype = 1'b1; dec.alu_sel = ALU_SUB; end
                    FN_AND:  begin dec.legal = 1'b1; dec.rtype = 1'b1; dec.alu_sel = ALU_AND; end
                    FN_OR:   begin dec.legal = 1'b1; dec.rtype = 1'b1; dec.alu_sel = ALU_OR;  end
                    FN_SLT:  begin dec.legal = 1'b1; dec.rtype = 1'b1; dec.alu_sel = ALU_SLT; end
                    default: dec.legal = 1'b0;
                endcase
            end
            OP_ADDI: begin dec.legal = 1'b1; dec.imm_alu = 1'b1; dec.alu_sel = ALU_ADD; end
            OP_LW:   begin dec.legal = 1'b1; dec.load    = 1'b1; dec.alu_sel = ALU_ADD; end
            OP_SW:   begin dec.legal = 1'b1; dec.store   = 1'b1; dec.alu_sel = ALU_ADD; end
            OP_BEQ:  begin dec.legal = 1'b1; dec.branch  = 1'b1; dec.alu_sel = ALU_SUB; end
            OP_J:    begin dec.legal = 1'b1; dec.jump    = 1'b1; end
            OP_HALT: dec.halt = 1'b1;
            default: dec.legal = 1'b0;
        endcase
    end

    // Next-state, architectural updates and control outputs; all outputs
    // depend only on registered state and IR, never on live inputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;

        alu_phase = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
        fetch_req = (state_q == S_FETCH);
        halted    = (state_q == S_HALT);
        br        = (state_q == S_EXEC) && dec.branch;
        regdst    = dec.rtype && ((state_q == S_EXEC) || (state_q == S_WB));
        alusrc    = alu_phase && (dec.imm_alu || dec.load || dec.store);
        sel       = alu_phase ? dec.alu_sel : ALU_AND;
        mem_re    = (state_q == S_MEM) && dec.load;
        mem_we    = (state_q == S_MEM) && dec.store;
        enable    = (state_q == S_WB);
        memtoreg  = (state_q == S_WB) && dec.load;

        unique case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.halt) begin
                    state_d = S_HALT;
                end else if (dec.legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                if (dec.rtype || dec.imm_alu) begin
                    state_d = S_WB;
                end else if (dec.load || dec.store) begin
                    state_d = S_MEM;
                end else if (dec.branch) begin
                    // pc already points past the branch, so the offset is relative to pc+4
                    if (zero) begin
                        pc_d = pc_q + (sign_ext << 2);
                    end
                    state_d = S_FETCH;
                end else begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                state_d = dec.load ? S_WB : S_FETCH;
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0000;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc      = pc_q;
    assign sign    = sign_ext;
    assign illegal = illegal_q;

`ifndef SYNTHESIS
    always_comb begin
        assert ($countones({enable, mem_we, mem_re, br}) <= 1);
    end
`endif

endmodule

// File: tb/tb_ctrl_fetch_fsm.sv
// Bench for ctrl_fetch_fsm: directed vector table, corner sequences, random instruction stream.
`timescale 1ns/1ps
module tb_ctrl_fetch_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        zero;
    logic [31:0] pc;
    logic        fetch_req;
    logic        br;
    logic        regdst;
    logic        enable;
    logic        alusrc;
    logic [31:0] sign;
    logic [3:0]  sel;
    logic        mem_re;
    logic        mem_we;
    logic        memtoreg;
    logic        halted;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ctrl_fetch_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .zero        (zero),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .br          (br),
        .regdst      (regdst),
        .enable      (enable),
        .alusrc      (alusrc),
        .sign        (sign),
        .sel         (sel),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .memtoreg    (memtoreg),
        .halted      (halted),
        .illegal     (illegal)
    );

    // Observable summary of one instruction's execution.
    typedef struct {
        logic [31:0] cycles;
        logic [31:0] pc_after;
        logic [31:0] sel;
        logic [31:0] regdst;
        logic [31:0] alusrc;
        logic [31:0] sign;
        logic [31:0] n_en;
        logic [31:0] n_re;
        logic [31:0] n_we;
        logic [31:0] n_br;
        logic [31:0] n_mtr;
        logic [31:0] ill;
        logic [31:0] n_excl;
    } res_t;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          wait_n;
        res_t        exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] ins, input logic z, input int w,
                           input logic [31:0] cyc, input logic [31:0] pc_a, input logic [31:0] sl,
                           input logic [31:0] rd, input logic [31:0] as, input logic [31:0] sg,
                           input logic [31:0] en, input logic [31:0] re, input logic [31:0] we,
                           input logic [31:0] b, input logic [31:0] mtr, input logic [31:0] il);
        vec_t v;
        v.ins = ins; v.z = z; v.wait_n = w;
        v.exp.cycles = cyc; v.exp.pc_after = pc_a; v.exp.sel = sl; v.exp.regdst = rd;
        v.exp.alusrc = as; v.exp.sign = sg; v.exp.n_en = en; v.exp.n_re = re;
        v.exp.n_we = we; v.exp.n_br = b; v.exp.n_mtr = mtr; v.exp.ill = il; v.exp.n_excl = 0;
        vecs.push_back(v);
    endtask

    // Reference: what the instruction should do, from the ISA rules alone.
    function automatic res_t model(input logic [31:0] pc0, input logic [31:0] ins,
                                   input logic z, input logic ill_prev);
        res_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] nxt;
        op  = ins[31:26];
        fn  = ins[5:0];
        nxt = pc0 + 32'd4;
        e.cycles = 2; e.pc_after = nxt; e.sel = 0; e.regdst = 0; e.alusrc = 0;
        e.sign = {{16{ins[15]}}, ins[15:0]};
        e.n_en = 0; e.n_re = 0; e.n_we = 0; e.n_br = 0; e.n_mtr = 0; e.n_excl = 0;
        e.ill = 1;
        if (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
            e.cycles = 4; e.n_en = 1; e.regdst = 1; e.ill = 32'(ill_prev);
            case (fn)
                6'h20:   e.sel = 32'h2;
                6'h22:   e.sel = 32'h6;
                6'h24:   e.sel = 32'h0;
                6'h25:   e.sel = 32'h1;
                default: e.sel = 32'h7;
            endcase
        end else if (op == 6'h08) begin
            e.cycles = 4; e.n_en = 1; e.alusrc = 1; e.sel = 32'h2; e.ill = 32'(ill_prev);
        end else if (op == 6'h23) begin
            e.cycles = 5; e.n_en = 1; e.n_re = 1; e.n_mtr = 1; e.alusrc = 1; e.sel = 32'h2;
            e.ill = 32'(ill_prev);
        end else if (op == 6'h2B) begin
            e.cycles = 4; e.n_we = 1; e.alusrc = 1; e.sel = 32'h2; e.ill = 32'(ill_prev);
        end else if (op == 6'h04) begin
            e.cycles = 3; e.n_br = 1; e.sel = 32'h6; e.ill = 32'(ill_prev);
            e.pc_after = z ? nxt + (e.sign << 2) : nxt;
        end else if (op == 6'h02) begin
            e.cycles = 3; e.ill = 32'(ill_prev);
            e.pc_after = {nxt[31:28], ins[25:0], 2'b00};
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0; zero = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH back to FETCH, sampling on negedges.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic z,
                             input int wait_n, output res_t r);
        logic [31:0] pc0;
        int          n;
        bit          done;
        r.cycles = 1; r.pc_after = 0; r.sel = 0; r.regdst = 0; r.alusrc = 0; r.sign = 0;
        r.n_en = 0; r.n_re = 0; r.n_we = 0; r.n_br = 0; r.n_mtr = 0; r.ill = 0; r.n_excl = 0;
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s.fetch_ready", tag), 32'(fetch_req), 32'h1);
        pc0 = pc;
        for (int i = 0; i < wait_n; i++) begin
            instr = $urandom; instr_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("%s.wait%0d_pc", tag, i), pc, pc0);
            chk($sformatf("%s.wait%0d_req", tag, i), 32'(fetch_req), 32'h1);
            chk($sformatf("%s.wait%0d_strobes", tag, i),
                32'({enable, mem_we, mem_re, br, memtoreg}), 32'h0);
        end
        instr = ins; instr_valid = 1'b1; zero = z;
        @(negedge clk);
        instr = $urandom; instr_valid = 1'b0;
        done = 1'b0;
        for (int k = 1; k <= 10 && !done; k++) begin
            if (fetch_req === 1'b1) begin
                done = 1'b1;
            end else begin
                r.cycles++;
                if (k == 1) r.sign = sign;
                if (k == 2) begin
                    r.sel = 32'(sel); r.regdst = 32'(regdst); r.alusrc = 32'(alusrc);
                end
                if (enable)              r.n_en++;
                if (mem_re)              r.n_re++;
                if (mem_we)              r.n_we++;
                if (br)                  r.n_br++;
                if (enable && memtoreg)  r.n_mtr++;
                if ($countones({enable, mem_we, mem_re, br}) > 1) r.n_excl++;
                @(negedge clk);
            end
        end
        r.pc_after = pc;
        r.ill      = 32'(illegal);
    endtask

    task automatic cmp_res(input string tag, input res_t r, input res_t e);
        chk($sformatf("%s.cycles", tag), r.cycles, e.cycles);
        chk($sformatf("%s.pc", tag), r.pc_after, e.pc_after);
        chk($sformatf("%s.sel", tag), r.sel, e.sel);
        chk($sformatf("%s.regdst", tag), r.regdst, e.regdst);
        chk($sformatf("%s.alusrc", tag), r.alusrc, e.alusrc);
        chk($sformatf("%s.sign", tag), r.sign, e.sign);
        chk($sformatf("%s.n_enable", tag), r.n_en, e.n_en);
        chk($sformatf("%s.n_mem_re", tag), r.n_re, e.n_re);
        chk($sformatf("%s.n_mem_we", tag), r.n_we, e.n_we);
        chk($sformatf("%s.n_br", tag), r.n_br, e.n_br);
        chk($sformatf("%s.n_memtoreg", tag), r.n_mtr, e.n_mtr);
        chk($sformatf("%s.illegal", tag), r.ill, e.ill);
        chk($sformatf("%s.exclusive", tag), r.n_excl, e.n_excl);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t        r;
        res_t        e;
        logic [31:0] ins;
        logic [31:0] mpc;
        logic        mill;
        logic [5:0]  op;
        logic        z;
        logic [5:0]  fn_tab [5];
        int          kind;
        int          k;

        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
        fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A;

        //       instr         z  wait cyc pc_after     sel rd as sign          en re we br mtr ill
        add_vec(32'h20010006, 0, 5,   4, 32'h004,   2, 0, 1, 32'h00000006, 1, 0, 0, 0, 0, 0);
        add_vec(32'h00221820, 0, 0,   4, 32'h008,   2, 1, 0, 32'h00001820, 1, 0, 0, 0, 0, 0);
        add_vec(32'h1000FFFE, 1, 0,   3, 32'h004,   6, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 1, 0, 0);
        add_vec(32'h00221822, 0, 0,   4, 32'h008,   6, 1, 0, 32'h00001822, 1, 0, 0, 0, 0, 0);
        add_vec(32'h1000FFFE, 0, 0,   3, 32'h00C,   6, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 1, 0, 0);
        add_vec(32'h8C220010, 0, 0,   5, 32'h010,   2, 0, 1, 32'h00000010, 1, 1, 0, 0, 1, 0);
        add_vec(32'hAC220010, 0, 0,   4, 32'h014,   2, 0, 1, 32'h00000010, 0, 0, 1, 0, 0, 0);
        add_vec(32'h00221824, 0, 0,   4, 32'h018,   0, 1, 0, 32'h00001824, 1, 0, 0, 0, 0, 0);
        add_vec(32'h00221825, 0, 1,   4, 32'h01C,   1, 1, 0, 32'h00001825, 1, 0, 0, 0, 0, 0);
        add_vec(32'h0022182A, 0, 0,   4, 32'h020,   7, 1, 0, 32'h0000182A, 1, 0, 0, 0, 0, 0);
        add_vec(32'h08000040, 0, 0,   3, 32'h100,   0, 0, 0, 32'h00000040, 0, 0, 0, 0, 0, 0);
        add_vec(32'h2001FFFF, 0, 0,   4, 32'h104,   2, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
        add_vec(32'h54000000, 0, 0,   2, 32'h108,   0, 0, 0, 32'h00000000, 0, 0, 0, 0, 0, 1);
        add_vec(32'h00221800, 0, 0,   2, 32'h10C,   0, 0, 0, 32'h00001800, 0, 0, 0, 0, 0, 1);
        add_vec(32'h20010001, 0, 0,   4, 32'h110,   2, 0, 1, 32'h00000001, 1, 0, 0, 0, 0, 1);

        // Reset values
        do_reset();
        chk("reset.pc", pc, 32'h0);
        chk("reset.fetch_req", 32'(fetch_req), 32'h1);
        chk("reset.ctrl", 32'({br, regdst, enable, alusrc, mem_re, mem_we, memtoreg, halted, illegal}), 32'h0);
        chk("reset.sign", sign, 32'h0);
        chk("reset.sel", 32'(sel), 32'h0);

        foreach (vecs[i]) begin
            run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].z, vecs[i].wait_n, r);
            cmp_res($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // PC wraps through 32'hFFFF_FFFC back to 0
        do_reset();
        run_instr("wrap_beq", 32'h1000FFFE, 1'b1, 0, r);
        chk("wrap_beq.pc", r.pc_after, 32'hFFFF_FFFC);
        run_instr("wrap_addi", 32'h20010006, 1'b0, 0, r);
        chk("wrap_addi.pc", r.pc_after, 32'h0);

        // Random instruction stream against the reference model
        do_reset();
        mpc  = 32'h0;
        mill = 1'b0;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 10);
            ins  = $urandom;
            z    = 1'($urandom_range(0, 1));
            case (kind)
                0, 1, 2, 3, 4: begin ins[31:26] = 6'h00; ins[5:0] = fn_tab[kind]; end
                5:  ins[31:26] = 6'h08;
                6:  ins[31:26] = 6'h23;
                7:  ins[31:26] = 6'h2B;
                8:  ins[31:26] = 6'h04;
                9:  ins[31:26] = 6'h02;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F}) op = 6'h15;
                    ins[31:26] = op;
                end
            endcase
            e = model(mpc, ins, z, mill);
            run_instr($sformatf("rnd%0d", n), ins, z, $urandom_range(0, 2), r);
            cmp_res($sformatf("rnd%0d", n), r, e);
            mpc  = e.pc_after;
            mill = e.ill[0];
        end

        // Reset asserted during WB of addi aborts it at once
        do_reset();
        instr = 32'h20010006; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        k = 0;
        while (enable !== 1'b1 && k < 6) begin
            @(negedge clk);
            k++;
        end
        chk("rst_wb.reached_wb", 32'(enable), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_wb.enable", 32'(enable), 32'h0);
        chk("rst_wb.pc", pc, 32'h0);
        chk("rst_wb.fetch_req", 32'(fetch_req), 32'h1);
        chk("rst_wb.strobes", 32'({br, enable, mem_re, mem_we, memtoreg}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // HALT: frozen until reset even with instructions offered
        instr = 32'hFC000000; instr_valid = 1'b1;
        @(negedge clk);
        instr = 32'h20010006;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("halt%0d.halted", i), 32'(halted), 32'h1);
            chk($sformatf("halt%0d.pc", i), pc, 32'h4);
            chk($sformatf("halt%0d.quiet", i),
                32'({fetch_req, br, enable, mem_re, mem_we, memtoreg}), 32'h0);
            @(negedge clk);
        end
        chk("halt.illegal", 32'(illegal), 32'h0);
        instr_valid = 1'b0;
        do_reset();
        chk("halt_reset.halted", 32'(halted), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
